// File: rtl/instr_fetch.sv
// Instruction fetch and sequencing unit: owns the PC, drives a synchronous
// instruction ROM, presents instructions to the decoder and resolves BLQZ/halt.
module instr_fetch #(
   parameter int PC_W       = 10,
   parameter int INSTR_W    = 9,
   parameter int START_ADDR = 0,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   input  logic               branch_cond,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [2:0]         opcode,
   output logic               instr_valid,
   output logic               done,
   output logic [CNT_W-1:0]   retired,
   output logic [1:0]         dbg_state
);

   // Handshake: instr/opcode are meaningful only while instr_valid is high.
   // The consumer holds an instruction by raising stall; an EXEC cycle with
   // stall low is the transfer, after which the next fetch begins.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [2:0]      OP_BLQZ  = 3'b111;
   localparam logic [PC_W-1:0] PC_START = PC_W'(START_ADDR);

   state_t             state, state_nxt;
   logic [PC_W-1:0]    pc, pc_nxt;
   logic [CNT_W-1:0]   ret_q, ret_nxt, ret_inc;
   logic [PC_W-1:0]    off_ext;
   logic               is_blqz, is_halt;

   assign imem_addr = pc;
   assign retired   = ret_q;
   assign dbg_state = state;

   assign off_ext = {{(PC_W-6){imem_rdata[5]}}, imem_rdata[5:0]};
   assign is_blqz = (imem_rdata[INSTR_W-1 -: 3] == OP_BLQZ);
   assign is_halt = is_blqz && (imem_rdata[5:0] == 6'd0);
   assign ret_inc = (ret_q == {CNT_W{1'b1}}) ? ret_q : ret_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= PC_START;
         ret_q <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ret_q <= ret_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      ret_nxt     = ret_q;
      instr       = '0;
      opcode      = '0;
      instr_valid = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               state_nxt = FETCH;
               pc_nxt    = PC_START;
               ret_nxt   = '0;
            end
         end
         FETCH: state_nxt = EXEC;
         EXEC: begin
            instr       = imem_rdata;
            opcode      = imem_rdata[INSTR_W-1 -: 3];
            instr_valid = 1'b1;
            if (!stall) begin
               ret_nxt = ret_inc;
               if (is_halt) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = FETCH;
                  // PC arithmetic wraps naturally at PC_W bits.
                  if (is_blqz && branch_cond) pc_nxt = pc + off_ext;
                  else                        pc_nxt = pc + PC_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// programs and control inputs, checked every cycle against a program-level model.
module tb_instr_fetch;
   localparam int PC_W   = 10;
   localparam int INSTR_W = 9;
   localparam int CNT_W  = 16;
   localparam int PC_MOD = 1 << PC_W;

   // model phases
   localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_DONE = 3;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               stall = 1'b0;
   logic               branch_cond = 1'b0;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata = '0;
   logic [INSTR_W-1:0] instr;
   logic [2:0]         opcode;
   logic               instr_valid;
   logic               done;
   logic [CNT_W-1:0]   retired;
   logic [1:0]         dbg_state;

   logic [INSTR_W-1:0] rom [0:PC_MOD-1];

   int n_tests = 0;
   int n_fail  = 0;
   int m_phase = M_IDLE;
   int m_pc    = 0;
   int m_ret   = 0;

   instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .START_ADDR(0), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .branch_cond(branch_cond), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .done(done),
      .retired(retired), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // synchronous ROM: data for an address appears one cycle after it is presented
   always @(posedge clk) imem_rdata <= rom[imem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Program-level model: what one clock edge does to the visible machine.
   task automatic model_edge();
      int w, op, off, soff;
      if (!rst_n) begin
         m_phase = M_IDLE; m_pc = 0; m_ret = 0;
         return;
      end
      case (m_phase)
         M_IDLE, M_DONE:
            if (start) begin m_phase = M_FETCH; m_pc = 0; m_ret = 0; end
         M_FETCH: m_phase = M_EXEC;
         default: if (!stall) begin
            w = int'(rom[m_pc]);
            op = w >> 6;
            off = w & 63;
            m_ret = (m_ret + 1 > (1 << CNT_W) - 1) ? m_ret : m_ret + 1;
            if (op == 7 && off == 0) m_phase = M_DONE;
            else begin
               m_phase = M_FETCH;
               soff = (off >= 32) ? off - 64 : off;
               if (op == 7 && branch_cond) m_pc = (m_pc + soff + PC_MOD) % PC_MOD;
               else                        m_pc = (m_pc + 1) % PC_MOD;
            end
         end
      endcase
   endtask

   task automatic check_all();
      int exp_instr;
      exp_instr = (m_phase == M_EXEC) ? int'(rom[m_pc]) : 0;
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("instr_valid", 32'(instr_valid), 32'(m_phase == M_EXEC));
      chk("instr", 32'(instr), 32'(exp_instr));
      chk("opcode", 32'(opcode), 32'(exp_instr >> 6));
      chk("done", 32'(done), 32'(m_phase == M_DONE));
      chk("retired", 32'(retired), 32'(m_ret));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; step(); rst_n = 1'b1;
   endtask

   task automatic do_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < PC_MOD; i++) rom[i] = '0;
   endtask

   task automatic wait_exec_at(input int addr, input int budget);
      bit found = 0;
      for (int i = 0; i < budget && !found; i++) begin
         if (m_phase == M_EXEC && m_pc == addr) found = 1;
         else step();
      end
      if (!found) chk("wait_exec_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int w;
      clear_rom();
      do_reset(); do_reset();
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // straight line: ADD, XOR, MOV, halt
      rom[0] = 9'b000_000000; rom[1] = 9'b001_000000;
      rom[2] = 9'b100_000000; rom[3] = 9'b111_000000;
      do_start();
      chk("sl_fetch_valid", 32'(instr_valid), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("sl_valid", 32'(instr_valid), 32'(k % 2));
         if (k == 1) chk("sl_op0", 32'(opcode), 32'd0);
         if (k == 3) chk("sl_op1", 32'(opcode), 32'd1);
         if (k == 5) chk("sl_op2", 32'(opcode), 32'd4);
         if (k == 7) chk("sl_op3", 32'(opcode), 32'd7);
      end
      chk("sl_done", 32'(done), 32'd1);
      chk("sl_retired", 32'(retired), 32'd4);

      // start in DONE restarts at 0 with a cleared count
      do_start();
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_addr", 32'(imem_addr), 32'd0);
      chk("restart_ret", 32'(retired), 32'd0);

      // start during EXEC is ignored
      wait_exec_at(1, 20);
      start = 1'b1; step(); start = 1'b0;
      chk("ign_start_addr", 32'(imem_addr), 32'd2);

      // reset mid-program while stalled in EXEC
      do_reset(); clear_rom();
      do_start();
      wait_exec_at(3, 20);
      stall = 1'b1; step();
      rst_n = 1'b0; step(); rst_n = 1'b1; stall = 1'b0;
      chk("rstx_valid", 32'(instr_valid), 32'd0);
      chk("rstx_addr", 32'(imem_addr), 32'd0);
      chk("rstx_ret", 32'(retired), 32'd0);

      // branch taken / not taken: BLQZ -3 at 5
      rom[5] = 9'b111_111101; rom[6] = 9'b111_000000;
      for (int bc = 1; bc >= 0; bc--) begin
         do_reset();
         branch_cond = 1'(bc);
         do_start();
         wait_exec_at(5, 30);
         step();
         chk("br_target", 32'(imem_addr), (bc == 1) ? 32'd2 : 32'd6);
      end
      branch_cond = 1'b0;

      // stall on LD at 4
      do_reset(); clear_rom();
      rom[4] = 9'b101_000000;
      do_start();
      wait_exec_at(4, 30);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("st_valid", 32'(instr_valid), 32'd1);
         chk("st_opcode", 32'(opcode), 32'd5);
         chk("st_addr", 32'(imem_addr), 32'd4);
         chk("st_ret", 32'(retired), 32'd4);
      end
      stall = 1'b0; step();
      chk("st_next_addr", 32'(imem_addr), 32'd5);
      chk("st_ret_once", 32'(retired), 32'd5);

      // wrap: 0 -> 1023 via BLQZ -1, ALU op at 1023 -> 0
      do_reset(); clear_rom();
      branch_cond = 1'b1;
      rom[0] = 9'b111_111111;
      do_start();
      wait_exec_at(1023, 20);
      step();
      chk("wrap_fwd", 32'(imem_addr), 32'd0);
      // BLQZ +2 at 1022 taken -> 0
      do_reset();
      rom[0] = 9'b111_111110; rom[1022] = 9'b111_000010;
      do_start();
      wait_exec_at(1022, 20);
      step();
      chk("wrap_br", 32'(imem_addr), 32'd0);
      branch_cond = 1'b0;

      // randomized programs and control
      do_reset();
      for (int i = 0; i < PC_MOD; i++) begin
         w = int'($urandom_range(0, 7)) << 6;
         w = w | int'($urandom_range(0, 63));
         if ((w >> 6) == 7 && $urandom_range(0, 3) == 0) w = 7 << 6;
         rom[i] = INSTR_W'(w);
      end
      for (int c = 0; c < 20000; c++) begin
         start       = ($urandom_range(0, 3) == 0);
         stall       = ($urandom_range(0, 2) == 0);
         branch_cond = 1'($urandom_range(0, 1));
         rst_n       = ($urandom_range(0, 299) != 0);
         if ((m_phase == M_IDLE || m_phase == M_DONE) && $urandom_range(0, 9) == 0)
            rom[$urandom_range(0, 31)] = INSTR_W'($urandom_range(0, 511));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
